// File: rtl/ib_capture_fifo.sv
// ib_capture_fifo
//
// Purpose: captures 4-bit nibbles from an internal bus into a 4-entry FIFO.
// A request from IDLE is answered by a three-state transfer: DRIVE enables
// the source register's bus drivers and lets the bus settle, SAMPLE keeps
// them enabled, and the bus value is written to the FIFO tail on the
// SAMPLE->IDLE edge. A request arriving while the FIFO is full is refused
// and latches the sticky Overflow flag.
//
// Ports:
//   MainClock  in   sole clock, rising edge
//   ClearN     in   asynchronous active-low reset
//   Req        in   capture request (level, ignored while a transfer runs)
//   IB         in   4-bit internal bus, stored exactly as sampled
//   EnableOut  out  bus driver enable, high during DRIVE and SAMPLE
//   OutData    out  FIFO head entry
//   OutValid   out  FIFO not empty
//   OutReady   in   consumer accept; pop when OutValid & OutReady
//   Count      out  FIFO occupancy, 0..4
//   Busy       out  transfer FSM not in IDLE
//   Overflow   out  sticky: a request was refused because the FIFO was full

module ib_capture_fifo (
  input  logic       MainClock,
  input  logic       ClearN,
  input  logic       Req,
  input  logic [3:0] IB,
  output logic       EnableOut,
  output logic [3:0] OutData,
  output logic       OutValid,
  input  logic       OutReady,
  output logic [2:0] Count,
  output logic       Busy,
  output logic       Overflow
);

  localparam int DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2
  } stateT;

  stateT      stateReg;
  stateT      stateNext;

  logic [3:0] fifoMem [DEPTH];
  logic [1:0] rdPtrReg;
  logic [1:0] wrPtrReg;
  logic [2:0] countReg;
  logic       overflowReg;

  logic       fifoFull;
  logic       acceptReq;
  logic       refuseReq;
  logic       pushNow;
  logic       popNow;

  // Occupancy is judged on the pre-edge count; a pop on the same edge does
  // not open room for a new transfer.
  assign fifoFull  = (countReg == 3'd4);
  assign acceptReq = (stateReg == IDLE) && Req && !fifoFull;
  assign refuseReq = (stateReg == IDLE) && Req && fifoFull;
  // Only one transfer is ever in flight and it was admitted with room to
  // spare, so a push in SAMPLE always fits even if no pop happens.
  assign pushNow   = (stateReg == SAMPLE);
  assign popNow    = (countReg != 3'd0) && OutReady;

  // Transfer FSM: state register
  always_ff @(posedge MainClock or negedge ClearN) begin
    if (!ClearN) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Transfer FSM: next state
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (acceptReq) stateNext = DRIVE;
      DRIVE:   stateNext = SAMPLE;
      SAMPLE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FIFO storage: one register per entry so every entry clears on reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
    always_ff @(posedge MainClock or negedge ClearN) begin
      if (!ClearN) begin
        fifoMem[gi] <= 4'h0;
      end else if (pushNow && (wrPtrReg == 2'(gi))) begin
        fifoMem[gi] <= IB;
      end
    end
  end

  // Pointers and occupancy; 2-bit pointers wrap from 3 to 0 naturally.
  always_ff @(posedge MainClock or negedge ClearN) begin
    if (!ClearN) begin
      rdPtrReg <= 2'd0;
      wrPtrReg <= 2'd0;
      countReg <= 3'd0;
    end else begin
      if (pushNow) wrPtrReg <= wrPtrReg + 2'd1;
      if (popNow)  rdPtrReg <= rdPtrReg + 2'd1;
      case ({pushNow, popNow})
        2'b10:   countReg <= countReg + 3'd1;
        2'b01:   countReg <= countReg - 3'd1;
        default: countReg <= countReg;
      endcase
    end
  end

  // Sticky overflow, cleared only by reset.
  always_ff @(posedge MainClock or negedge ClearN) begin
    if (!ClearN) begin
      overflowReg <= 1'b0;
    end else if (refuseReq) begin
      overflowReg <= 1'b1;
    end
  end

  // All outputs decode registered state only.
  assign EnableOut = (stateReg == DRIVE) || (stateReg == SAMPLE);
  assign Busy      = (stateReg != IDLE);
  assign Count     = countReg;
  assign OutValid  = (countReg != 3'd0);
  assign OutData   = fifoMem[rdPtrReg];
  assign Overflow  = overflowReg;

endmodule

// File: doc/ib_capture_fifo.md
IB_CAPTURE_FIFO -- requirements
Module: ib_capture_fifo

Interface
REQ-001 The block SHALL have the ports listed in REQ-002 to REQ-011. It SHALL use one clock, MainClock, and an asynchronous active-low reset, ClearN.
REQ-002 MainClock  in  1  sole clock; all state updates on the rising edge.
REQ-003 ClearN  in  1  asynchronous, active-low reset.
REQ-004 Req  in  1  request to read one nibble from the internal bus; level, sampled each edge.
REQ-005 IB  in  4  internal bus, driven by the source register's inverting tristate when enabled.
REQ-006 EnableOut  out  1  enable strobe to the source register's bus drivers.
REQ-007 OutData  out  4  head entry of the FIFO.
REQ-008 OutValid  out  1  high when the FIFO holds at least one entry.
REQ-009 OutReady  in  1  consumer accept; a pop occurs on an edge where OutValid=1 and OutReady=1.
REQ-010 Count  out  3  FIFO occupancy, 0 to 4.
REQ-011 Busy / Overflow  out  1 each:
- Busy: transfer FSM not IDLE.
- Overflow: sticky flag for a refused request.

Function
REQ-012 Transfer FSM states SHALL be IDLE, DRIVE and SAMPLE; all outputs SHALL be Moore-decoded from registers.
REQ-013 IDLE->DRIVE SHALL occur when, at an edge, state=IDLE, Req=1 and Count<4.
- Count is the pre-edge value; a pop on the same edge does not count.
REQ-014 DRIVE->SAMPLE and SAMPLE->IDLE SHALL be unconditional, one edge each.
REQ-015 EnableOut SHALL be 1 exactly while state is DRIVE or SAMPLE.
- DRIVE is the bus-settle cycle; no capture occurs in DRIVE.
REQ-016 On the SAMPLE->IDLE edge, IB SHALL be written to the FIFO tail exactly as sampled; no inversion is applied.
REQ-017 Latency SHALL be as follows, for Req accepted at edge N:
- EnableOut high from after N until after N+2.
- Data written at N+2.
- OutValid=1 after N+2 if the FIFO was empty.
REQ-018 Req SHALL be ignored while state is DRIVE or SAMPLE.
- Requests are not queued.
- Maximum throughput is one transfer per 3 cycles, with the next accept at edge N+3.
REQ-019 The FIFO SHALL be 4 deep with circular 2-bit read and write pointers that wrap from 3 to 0. OutData SHALL equal the entry at the read pointer.
REQ-020 A push and a pop on the same edge SHALL leave Count unchanged and move both pointers.
REQ-021 A pop with Count=0 SHALL be impossible, because OutValid=0. OutReady SHALL be don't-care while OutValid=0.
REQ-022 While OutValid=0, OutData SHALL hold the last value read at the read pointer, with no forced zero.
REQ-023 Overflow handling, for Req=1 in IDLE with Count=4:
- The FIFO SHALL stay unchanged and the FSM SHALL stay in IDLE.
- Overflow SHALL be set at that edge.
- Overflow SHALL be cleared only by reset.
REQ-024 Count SHALL never exceed 4, and Busy SHALL equal (state != IDLE).

Reset
REQ-025 ClearN=0 SHALL immediately force the following, independent of MainClock:
- FSM to IDLE, EnableOut=0, Busy=0.
- Pointers to 0, Count=0, OutValid=0, OutData=0.
- Overflow=0 and all FIFO entries to 0.
REQ-026 A reset during DRIVE or SAMPLE SHALL abort the transfer:
- The partial transfer is not captured.
- EnableOut falls at reset assertion.
REQ-027 After ClearN rises, the first edge SHALL evaluate Req normally; there are no extra wait cycles.

Verification
REQ-028 Single transfer: IB=0xA, Req=1 for one edge (N), OutReady=0 -> EnableOut=1 for 2 cycles; OutValid=1, OutData=0xA, Count=1 after N+2.
REQ-029 Fill and overflow:
- Stimulus: 5 requests with IB=1,2,3,4,5 and OutReady=0.
- Response: Count=4 with entries 1,2,3,4 kept; the 5th is refused, Overflow=1, and EnableOut stays 0 for it.
REQ-030 Drain order and wrap:
- Stimulus: after REQ-029, OutReady=1 for 4 edges, then 4 more transfers (6,7,8,9), then drain again.
- Response: outputs 1,2,3,4 then 6,7,8,9; pointers wrap; Overflow remains 1.
REQ-031 Simultaneous push and pop:
- Stimulus: Count=2 and OutReady=1 on the SAMPLE->IDLE edge.
- Response: Count stays 2, the head advances and the new nibble lands at the tail.
REQ-032 Held Req: Req held high for 9 edges from IDLE, FIFO empty, OutReady=0 -> exactly 3 transfers; Busy pattern 1,1,0 repeated.
REQ-033 Reset mid-transfer: ClearN pulsed low during SAMPLE -> EnableOut=0, Count=0, OutValid=0 immediately; no entry written.
